// File: rtl/mc_control_if.sv
// Memory handshake bundle between mc_control (master) and the instruction/data memories (slave).
interface mc_control_if;
    logic im_req;
    logic im_ack;
    logic dm_req;
    logic dm_ack;
    logic dm_write_enable;

    modport master (
        output im_req,
        output dm_req,
        output dm_write_enable,
        input  im_ack,
        input  dm_ack
    );

    modport slave (
        input  im_req,
        input  dm_req,
        input  dm_write_enable,
        output im_ack,
        output dm_ack
    );
endinterface

// File: rtl/mc_control.sv
// mc_control: multicycle control FSM for a small MIPS subset with bounded memory waits and a sticky fault.
// Define CONTROL_PERF_CNT_EN to add the retired_cnt / cycle_cnt performance counters.
module mc_control #(
    parameter int ALU_OP_W    = 5,
    parameter int EXT_MODE_W  = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mc_control_if.master          mem,
    input  logic [31:0]           instr,
    input  logic                  alu_zero,
    output logic                  ir_load,
    output logic                  pc_enable,
    output logic [2:0]            npc_jump_mode,
    output logic                  rf_write_enable,
    output logic                  cm_rf_write_addr,
    output logic                  cm_rf_write_data,
    output logic                  cm_alu_num2,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [EXT_MODE_W-1:0] ext_mode,
    output logic [2:0]            state,
    output logic                  fault,
`ifdef CONTROL_PERF_CNT_EN
    output logic [31:0]           retired_cnt,
    output logic [31:0]           cycle_cnt,
`endif
    output logic [1:0]            fault_code
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    localparam logic [2:0]            NPC_WHEN_EQUAL = 3'd1;
    localparam logic [ALU_OP_W-1:0]   ALU_ADD        = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0]   ALU_SUB        = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0]   ALU_OR         = ALU_OP_W'(4);
    localparam logic [EXT_MODE_W-1:0] EXT_UNSIGNED   = EXT_MODE_W'(0);
    localparam logic [EXT_MODE_W-1:0] EXT_SIGNED     = EXT_MODE_W'(1);
    localparam logic [EXT_MODE_W-1:0] EXT_PAD        = EXT_MODE_W'(2);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        K_NONE, K_ADDU, K_SUBU, K_LUI, K_ORI, K_LW, K_SW, K_BEQ, K_NOP, K_ILLEGAL
    } kind_e;

    typedef struct packed {
        logic                  wr_rd;
        logic                  wr_mem;
        logic                  num2_ext;
        logic [ALU_OP_W-1:0]   alu;
        logic [EXT_MODE_W-1:0] ext;
        logic [2:0]            npc;
    } ctrl_t;

    function automatic kind_e decode_kind(input logic [31:0] ir);
        kind_e k;
        k = K_ILLEGAL;
        if (ir == 32'd0) begin
            k = K_NOP;
        end else begin
            case (ir[31:26])
                6'h00: begin
                    if (ir[5:0] == 6'h21)      k = K_ADDU;
                    else if (ir[5:0] == 6'h23) k = K_SUBU;
                end
                6'h0F:   k = K_LUI;
                6'h0D:   k = K_ORI;
                6'h23:   k = K_LW;
                6'h2B:   k = K_SW;
                6'h04:   k = K_BEQ;
                default: k = K_ILLEGAL;
            endcase
        end
        return k;
    endfunction

    function automatic ctrl_t ctrl_of(input kind_e k);
        ctrl_t c;
        c = '0;
        case (k)
            K_ADDU: begin c.wr_rd = 1'b1; c.alu = ALU_ADD; end
            K_SUBU: begin c.wr_rd = 1'b1; c.alu = ALU_SUB; end
            K_LUI:  begin c.num2_ext = 1'b1; c.alu = ALU_OR; c.ext = EXT_PAD; end
            K_ORI:  begin c.num2_ext = 1'b1; c.alu = ALU_OR; c.ext = EXT_UNSIGNED; end
            K_LW: begin
                c.wr_mem   = 1'b1;
                c.num2_ext = 1'b1;
                c.alu      = ALU_ADD;
                c.ext      = EXT_SIGNED;
            end
            K_SW:   begin c.num2_ext = 1'b1; c.alu = ALU_ADD; c.ext = EXT_SIGNED; end
            K_BEQ:  begin c.alu = ALU_SUB; c.npc = NPC_WHEN_EQUAL; end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;
    kind_e             dec_kind, act_kind;
    ctrl_t             act_ctrl;

    // alu_zero steers the NPC directly; the control sequence is identical for taken and not-taken beq.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    assign dec_kind = decode_kind(instr);
    assign wait_inc = wait_q + WAIT_W'(1);

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        wait_d       = wait_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        case (state_q)
            S_FETCH: begin
                if (mem.im_ack) begin
                    state_d = S_DECODE;
                end else if (wait_inc == WAIT_LIMIT) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd2;
                end
            end
            S_DECODE: begin
                kind_d = dec_kind;
                if (dec_kind == K_ILLEGAL) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd1;
                end else if (dec_kind == K_NOP) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (kind_q)
                    K_BEQ:      state_d = S_FETCH;
                    K_LW, K_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.dm_ack) begin
                    state_d = (kind_q == K_SW) ? S_FETCH : S_WB;
                end else if (wait_inc == WAIT_LIMIT) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd3;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: begin
                state_d      = S_FAULT;
                fault_code_d = 2'd1;
            end
        endcase

        if (state_d == S_FAULT) fault_d = 1'b1;

        // Any state change restarts the wait count, so FETCH and MEM always start from zero.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((state_q == S_FETCH && !mem.im_ack) || (state_q == S_MEM && !mem.dm_ack)) begin
            wait_d = wait_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            kind_q       <= K_NONE;
            wait_q       <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            wait_q       <= wait_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Datapath selects follow the live decode only in DECODE, the latched kind afterwards.
    always_comb begin
        act_kind = K_NONE;
        if (state_q == S_DECODE) begin
            act_kind = dec_kind;
        end else if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            act_kind = kind_q;
        end
    end

    assign act_ctrl = ctrl_of(act_kind);

    assign mem.im_req          = reset_n && (state_q == S_FETCH);
    assign mem.dm_req          = reset_n && (state_q == S_MEM);
    assign mem.dm_write_enable = mem.dm_req && (kind_q == K_SW);
    assign ir_load             = mem.im_req && mem.im_ack;
    assign rf_write_enable     = (state_q == S_WB);
    assign pc_enable           = ((state_q == S_DECODE) && (dec_kind == K_NOP))
                              || ((state_q == S_EXEC) && (kind_q == K_BEQ))
                              || (mem.dm_write_enable && mem.dm_ack)
                              || (state_q == S_WB);

    assign npc_jump_mode    = act_ctrl.npc;
    assign cm_rf_write_addr = act_ctrl.wr_rd;
    assign cm_rf_write_data = act_ctrl.wr_mem;
    assign cm_alu_num2      = act_ctrl.num2_ext;
    assign alu_op           = act_ctrl.alu;
    assign ext_mode         = act_ctrl.ext;
    assign state            = state_q;
    assign fault            = fault_q;
    assign fault_code       = fault_code_q;

`ifdef CONTROL_PERF_CNT_EN
    logic [31:0] retired_q, cycle_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= 32'd0;
            cycle_q   <= 32'd0;
        end else begin
            if (pc_enable)          retired_q <= retired_q + 32'd1;
            if (state_q != S_FAULT) cycle_q   <= cycle_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter ALU_OP_W, default 5: width of the alu_op output.
REQ-002 Parameter EXT_MODE_W, default 3: width of the ext_mode output.
REQ-003 Parameter MEM_TIMEOUT, default 15, legal range 1..255: maximum number of cycles spent waiting for an ack before a fault is raised.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 instr  in  32  instruction register contents; valid from DECODE onward.
REQ-007 im_ack  in  1  instruction memory has returned data.
REQ-008 dm_ack  in  1  data memory access is complete.
REQ-009 alu_zero  in  1  ALU operands are equal.
REQ-010 im_req  out  1  fetch request.
REQ-011 dm_req  out  1  data memory request.
REQ-012 ir_load  out  1  load the instruction register.
REQ-013 pc_enable  out  1  one-cycle PC update strobe.
REQ-014 npc_jump_mode  out  3  NPC jump mode, using the npc.h codes.
REQ-015 rf_write_enable  out  1  register file write strobe.
REQ-016 cm_rf_write_addr  out  1  0 selects rt, 1 selects rd.
REQ-017 cm_rf_write_data  out  1  0 selects the ALU result, 1 selects DM read data.
REQ-018 cm_alu_num2  out  1  0 selects RF read data 2, 1 selects the EXT result.
REQ-019 alu_op  out  ALU_OP_W  ALU operation, using the alu.h codes.
REQ-020 ext_mode  out  EXT_MODE_W  extender mode, using the ext.h codes.
REQ-021 dm_write_enable  out  1  data memory write.
REQ-022 state  out  3  current FSM state.
REQ-023 fault  out  1  sticky fault flag.
REQ-024 fault_code  out  2  1 = illegal instruction, 2 = IM timeout, 3 = DM timeout.

Function
REQ-025 State encoding SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
REQ-026 FETCH SHALL hold im_req=1 until im_ack; in the ack cycle it SHALL assert ir_load=1 for one cycle and go to DECODE.
REQ-027 DECODE SHALL latch the instruction kind (addu, subu, lui, ori, lw, sw, beq, nop).
REQ-028 From DECODE: unknown kind -> FAULT with code 1; nop -> pc_enable pulse, then FETCH; all other kinds -> EXEC.
REQ-029 EXEC for beq SHALL assert pc_enable with npc_jump_mode=WHEN_EQUAL, then go to FETCH; lw/sw -> MEM; other kinds -> WB.
REQ-030 MEM SHALL hold dm_req=1 until dm_ack; for sw, dm_write_enable SHALL equal dm_req and the ack cycle SHALL pulse pc_enable and go to FETCH; for lw the ack SHALL go to WB.
REQ-031 WB SHALL assert rf_write_enable=1 and pc_enable=1 for exactly one cycle, then go to FETCH.
REQ-032 Decode values: addu/subu use rd, ALU data, rf2, ADD/SUB; lui uses rt, ext, OR, PAD; ori uses rt, ext, OR, UNSIGNED; lw uses rt, DM data, ext, ADD, SIGNED; sw uses ext, ADD, SIGNED, with no RF write.
REQ-033 Control outputs SHALL be Moore functions of the registered state and the latched kind; no output SHALL depend combinationally on instr outside DECODE.
REQ-034 An ack arriving in the same cycle as the request SHALL be accepted; an ack arriving while no request is active SHALL be ignored.
REQ-035 Zero-wait latencies SHALL be: nop 2, beq 3, R-type/lui/ori/sw 4, lw 5 cycles.
REQ-036 A wait counter sized clog2(MEM_TIMEOUT+1) SHALL clear on entry to FETCH or MEM and count each cycle without ack.
REQ-037 When the wait counter reaches MEM_TIMEOUT, the FSM SHALL go to FAULT with code 2 (from FETCH) or 3 (from MEM).
REQ-038 FAULT SHALL be absorbing until reset, with all requests and enables at 0.

Reset
REQ-039 While reset_n=0: state=FETCH, fault=0, fault_code=0, wait counter=0, all strobes and requests=0, and remaining outputs=0.
REQ-040 reset_n asserted mid-operation SHALL abort any pending request immediately, without waiting for the clock.

Configuration
REQ-041 With CONTROL_PERF_CNT_EN defined, the block SHALL add outputs retired_cnt[31:0] (incremented per pc_enable pulse) and cycle_cnt[31:0] (incremented every non-FAULT cycle); both SHALL wrap at 2^32 and reset to 0.
REQ-042 With CONTROL_PERF_CNT_EN undefined, these ports and counters SHALL be absent.

Verification
REQ-043 addu 0x00221821, immediate acks -> states 0,1,2,4; in WB: rf_write_enable=1, cm_rf_write_addr=1, alu_op=ADD, one pc_enable.
REQ-044 lw 0x8C220004, dm_ack 3 cycles late -> dm_req high 4 cycles, then WB with cm_rf_write_data=1 and ext_mode=SIGNED.
REQ-045 sw 0xAC220004, dm_ack never asserted -> after 15 MEM cycles: state=7, fault=1, fault_code=3, all enables 0.
REQ-046 beq 0x10220003 with alu_zero=1 -> pc_enable and npc_jump_mode=WHEN_EQUAL in EXEC; 3 cycles total.
REQ-047 instr 0xFC000000 -> fault_code=1 one cycle after DECODE; reset_n pulsed low mid-MEM -> state=0 and all outputs 0 asynchronously.
REQ-048 With CONTROL_PERF_CNT_EN defined, 10 consecutive nops -> retired_cnt=10 and cycle_cnt=20.
